// File: rtl/mem_access_def.sv
// Shared load/store definitions: funct3 access-size codes, size decode
// helpers and the mem_access_stage FSM state encoding.
package mem_access_def;

  // funct3 access size / signedness codes
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Load/store stage FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Reserved funct3 encodings fall back to a full-word access
  function automatic mem_size_e decode_size(input logic [2:0] f3);
    case (f3)
      MEM_B, MEM_BU: decode_size = SZ_B;
      MEM_H, MEM_HU: decode_size = SZ_H;
      MEM_W:         decode_size = SZ_W;
      default:       decode_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] f3);
    is_unsigned = (f3 == MEM_BU) || (f3 == MEM_HU);
  endfunction

  // Halfword needs a[0]=0, word needs a[1:0]=0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (decode_size(f3))
      SZ_H:    is_misaligned = a[0];
      SZ_W:    is_misaligned = |a;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the load/store stage. Purely combinational.
// Store side (LOAD_SIDE=0): replicates store data into the selected lanes.
// Load side  (LOAD_SIDE=1): extracts the selected lane and sign/zero-extends.
// Both sides produce the byte enables for the access.
module mem_lane_align
  import mem_access_def::*;
#(
  parameter int XLEN      = 32,
  parameter bit LOAD_SIDE = 1'b0
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data_in,
  output logic [3:0]      be,
  output logic [XLEN-1:0] data_out
);

  mem_size_e       sz;
  logic            uns;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] store_val;
  logic [XLEN-1:0] load_val;

  assign sz        = decode_size(funct3);
  assign uns       = is_unsigned(funct3);
  assign byte_lane = data_in[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? data_in[31:16] : data_in[15:0];

  // Each byte lane picks its source byte from the access size
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_val[8*gi +: 8] = (sz == SZ_B) ? data_in[7:0] :
                                  (sz == SZ_H) ? data_in[8*(gi%2) +: 8] :
                                                 data_in[8*gi +: 8];
  end

  // Byte enables and extended load value from size and low address bits
  always_comb begin
    be       = 4'b1111;
    load_val = data_in;
    case (sz)
      SZ_B: begin
        be       = 4'b0001 << addr_lo;
        load_val = {{24{~uns & byte_lane[7]}}, byte_lane};
      end
      SZ_H: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        load_val = {{16{~uns & half_lane[15]}}, half_lane};
      end
      default: begin
        be       = 4'b1111;
        load_val = data_in;
      end
    endcase
  end

  assign data_out = LOAD_SIDE ? load_val : store_val;

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: runs one req/ack data-memory transaction per load or
// store, passes ALU ops straight through, and emits one write-back beat per
// accepted instruction.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// H/W accesses (exc_misalign pulse instead of a memory request).
module mem_access_stage
  import mem_access_def::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [XLEN-1:0]    store_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [RD_BITS-1:0] rd_in,
  input  logic               reg_write_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_valid,
  output logic [RD_BITS-1:0] wb_rd,
  output logic               wb_we,
  output logic [XLEN-1:0]    wb_data,
  output logic               exc_misalign,
  output logic [XLEN-1:0]    exc_addr
);

  logic [1:0]         state_reg, state_next;
  logic [XLEN-1:0]    addr_reg;
  logic [XLEN-1:0]    store_data_reg;
  logic [2:0]         funct3_reg;
  logic [RD_BITS-1:0] rd_reg;
  logic               reg_write_reg;
  logic               is_store_reg;
  logic [XLEN-1:0]    wb_data_reg;
  logic               trap_now;
  logic               in_req;
  logic               in_resp;
  logic [3:0]         store_be, load_be;
  logic [XLEN-1:0]    store_wdata, load_data;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_reg;
  assign trap_now = (mem_read | mem_write) & is_misaligned(funct3, alu_result[1:0]);
`else
  assign trap_now = 1'b0;
`endif

  assign in_ready = (state_reg == ST_IDLE);
  assign in_req   = (state_reg == ST_REQ);
  assign in_resp  = (state_reg == ST_RESP);

  // Store-side lanes: enables and replicated write data from latched operands
  mem_lane_align #(.XLEN(XLEN), .LOAD_SIDE(1'b0)) u_store_align (
    .funct3   (funct3_reg),
    .addr_lo  (addr_reg[1:0]),
    .data_in  (store_data_reg),
    .be       (store_be),
    .data_out (store_wdata)
  );

  // Load-side lanes: enables and extended read data
  mem_lane_align #(.XLEN(XLEN), .LOAD_SIDE(1'b1)) u_load_align (
    .funct3   (funct3_reg),
    .addr_lo  (addr_reg[1:0]),
    .data_in  (dmem_rdata),
    .be       (load_be),
    .data_out (load_data)
  );

  // Next-state: memory ops wait in REQ for ack, everything else goes to RESP
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if ((mem_read || mem_write) && !trap_now) state_next = ST_REQ;
          else                                      state_next = ST_RESP;
        end
      end
      ST_REQ:  if (dmem_ack) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, operand latch on accept, write-back data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      store_data_reg <= '0;
      funct3_reg     <= '0;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      is_store_reg   <= 1'b0;
      wb_data_reg    <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misalign_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (in_ready && in_valid) begin
        addr_reg       <= alu_result;
        store_data_reg <= store_data;
        funct3_reg     <= funct3;
        rd_reg         <= rd_in;
        reg_write_reg  <= reg_write_in;
        is_store_reg   <= mem_write;
        wb_data_reg    <= alu_result;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_reg   <= trap_now;
`endif
      end
      if (in_req && dmem_ack) wb_data_reg <= load_data;
    end
  end

  // Memory request outputs are held stable for the whole REQ state
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & is_store_reg;
  assign dmem_addr  = in_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = in_req ? (is_store_reg ? store_be : load_be) : 4'b0000;
  assign dmem_wdata = in_req ? store_wdata : '0;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign wb_valid     = in_resp & ~misalign_reg;
  assign exc_misalign = in_resp & misalign_reg;
  assign exc_addr     = exc_misalign ? addr_reg : '0;
`else
  assign wb_valid     = in_resp;
  assign exc_misalign = 1'b0;
  assign exc_addr     = '0;
`endif

  assign wb_we   = wb_valid & reg_write_reg & ~is_store_reg;
  assign wb_rd   = rd_reg;
  assign wb_data = wb_data_reg;

endmodule
